// File: rtl/vend_coin_scheduler.sv
// Coin front-end: captures sensor pulses and arbitrates them round-robin into a FIFO.
// It then issues one-hot coin pulses to the vending FSM, spaced by a settle/hold sequence.
module vend_coin_scheduler #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_nickel_req,
  input  logic             i_dime_req,
  input  logic             i_quarter_req,
  input  logic             i_soda,
  input  logic             i_vend_busy,
  output logic             o_nickel,
  output logic             o_dime,
  output logic             o_quarter,
  output logic             o_fifo_full,
  output logic             o_reject,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_coin_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, HOLD} state_t;

  logic [2:0]             req;
  logic [2:0]             pend_q, pend_d, grant;
  logic [1:0]             ptr_q, ptr_d, gidx, sel, code, pop_code;
  logic                   found, push, pop, can_push;
  logic [DEPTH-1:0][1:0]  mem_q, mem_d;
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic                   full_q, full_d;
  state_t                 state_q, state_d;
  logic [SW-1:0]          settle_q, settle_d;
  logic                   soda_q, soda_d;
  logic [2:0]             out_q, out_d;
  logic                   reject_q, reject_d, overflow_q, overflow_d;
  logic [CNT_W-1:0]       coin_q, coin_d;

  assign req = {i_quarter_req, i_dime_req, i_nickel_req};

  // Capture, round-robin arbitration and FIFO bookkeeping
  always_comb begin
    pop      = (state_q == IDLE) && (cnt_q != '0) && !i_vend_busy;
    // A same-cycle pop frees a slot, so a full FIFO may still accept a push.
    can_push = !full_q || pop;
    found    = 1'b0;
    gidx     = 2'd0;
    sel      = 2'd0;
    for (int k = 0; k < 3; k++) begin
      sel = 2'((int'(ptr_q) + k) % 3);
      if (!found && can_push && pend_q[sel]) begin
        found = 1'b1;
        gidx  = sel;
      end
    end
    push     = found;
    grant    = found ? (3'b001 << gidx) : 3'b000;
    ptr_d    = found ? ((gidx == 2'd2) ? 2'd0 : gidx + 2'd1) : ptr_q;
    code     = gidx + 2'd1;
    pop_code = mem_q[rd_q];

    pend_d     = (pend_q & ~grant) | req;
    reject_d   = |(req & pend_q & ~grant);
    overflow_d = overflow_q | reject_d;

    mem_d = mem_q;
    if (push) mem_d[wr_q] = code;
    wr_d   = wr_q + AW'(push);
    rd_d   = rd_q + AW'(pop);
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d = (cnt_d == (AW+1)'(DEPTH));
  end

  // Issue FSM
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    soda_d   = soda_q;
    out_d    = 3'b000;
    coin_d   = coin_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = ISSUE;
          out_d   = 3'b001 << (pop_code - 2'd1);
        end
      end
      ISSUE: begin
        state_d  = SETTLE;
        settle_d = SW'(GAP - 1);
        coin_d   = coin_q + CNT_W'(1);
      end
      SETTLE: begin
        if (i_soda) soda_d = 1'b1;
        if (settle_q == '0) begin
          if (soda_q || i_soda || i_vend_busy) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            soda_d  = 1'b0;
          end
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      HOLD: begin
        if (!i_vend_busy) begin
          state_d = IDLE;
          soda_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_q     <= '0;
      ptr_q      <= 2'd0;
      mem_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      state_q    <= IDLE;
      settle_q   <= '0;
      soda_q     <= 1'b0;
      out_q      <= 3'b000;
      reject_q   <= 1'b0;
      overflow_q <= 1'b0;
      coin_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      state_q    <= state_d;
      settle_q   <= settle_d;
      soda_q     <= soda_d;
      out_q      <= out_d;
      reject_q   <= reject_d;
      overflow_q <= overflow_d;
      coin_q     <= coin_d;
    end
  end

  assign o_nickel    = out_q[0];
  assign o_dime      = out_q[1];
  assign o_quarter   = out_q[2];
  assign o_fifo_full = full_q;
  assign o_reject    = reject_q;
  assign o_overflow  = overflow_q;
  assign o_coin_cnt  = coin_q;

endmodule

// File: tb/tb_vend_coin_scheduler.sv
// Directed bench for vend_coin_scheduler: pulse timing, ordering, hold-off, overflow, reset, wrap.
module tb_vend_coin_scheduler;

  logic       clk = 1'b0;
  logic       rst, nr, dr, qr, soda, busy;
  logic       on, od, oq, full, rej, ovf;
  logic [7:0] cnt;
  logic       w_n, w_d, w_q, w_full, w_rej, w_ovf;
  logic [1:0] w_cnt;

  int checks = 0, failures = 0;
  int npulse;
  int gi [16];
  int gc [16];

  always #5 clk = ~clk;

  vend_coin_scheduler #(.DEPTH(4), .GAP(2), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_nickel_req(nr), .i_dime_req(dr), .i_quarter_req(qr),
    .i_soda(soda), .i_vend_busy(busy), .o_nickel(on), .o_dime(od), .o_quarter(oq),
    .o_fifo_full(full), .o_reject(rej), .o_overflow(ovf), .o_coin_cnt(cnt));

  vend_coin_scheduler #(.DEPTH(4), .GAP(2), .CNT_W(2)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_nickel_req(nr), .i_dime_req(dr), .i_quarter_req(qr),
    .i_soda(soda), .i_vend_busy(busy), .o_nickel(w_n), .o_dime(w_d), .o_quarter(w_q),
    .o_fifo_full(w_full), .o_reject(w_rej), .o_overflow(w_ovf), .o_coin_cnt(w_cnt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_rec(input int i);
    step();
    checks++;
    if (int'(on) + int'(od) + int'(oq) > 1) begin
      failures++;
      $display("FAIL onehot step=%0d got=%b%b%b required at most one high", i, oq, od, on);
    end
    if ((on || od || oq) && npulse < 16) begin
      gi[npulse] = i;
      gc[npulse] = on ? 1 : (od ? 2 : 3);
      npulse++;
    end
  endtask

  task automatic clear_rec();
    npulse = 0;
    for (int k = 0; k < 16; k++) begin
      gi[k] = -1;
      gc[k] = -1;
    end
  endtask

  task automatic collect(input int n);
    clear_rec();
    for (int i = 1; i <= n; i++) step_rec(i);
  endtask

  task automatic do_reset();
    nr = 0; dr = 0; qr = 0; soda = 0; busy = 0;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    nr = 0; dr = 0; qr = 0; soda = 0; busy = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({on, od, oq, full, rej, ovf, cnt, w_cnt} !== 16'h0) begin
      failures++;
      $display("FAIL reset_state got=%b required=0", {on, od, oq, full, rej, ovf, cnt, w_cnt});
    end
    do_reset();
    step();
    checks++;
    if ({on, od, oq, full, rej, ovf, cnt} !== 14'h0) begin
      failures++;
      $display("FAIL reset_release got=%b required=0", {on, od, oq, full, rej, ovf, cnt});
    end
  endtask

  task automatic test_single_dime();
    do_reset();
    dr = 1;
    step();
    dr = 0;
    collect(8);
    checks++;
    if (npulse != 1 || gi[0] != 2 || gc[0] != 2) begin
      failures++;
      $display("FAIL single_dime got n=%0d at=%0d code=%0d required n=1 at=2 code=2", npulse, gi[0], gc[0]);
    end
    checks++;
    if (cnt !== 8'd1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL single_dime_cnt got cnt=%0d ovf=%b required cnt=1 ovf=0", cnt, ovf);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    nr = 1; dr = 1; qr = 1;
    step();
    nr = 0; dr = 0; qr = 0;
    collect(16);
    checks++;
    if (npulse != 3 || gi[0] != 2 || gi[1] != 6 || gi[2] != 10) begin
      failures++;
      $display("FAIL simul_timing got n=%0d at=%0d,%0d,%0d required n=3 at=2,6,10", npulse, gi[0], gi[1], gi[2]);
    end
    checks++;
    if (gc[0] != 1 || gc[1] != 2 || gc[2] != 3) begin
      failures++;
      $display("FAIL simul_order got=%0d,%0d,%0d required=1,2,3", gc[0], gc[1], gc[2]);
    end
    checks++;
    if (cnt !== 8'd3) begin
      failures++;
      $display("FAIL simul_cnt got=%0d required=3", cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    nr = 1;
    step();
    step();
    nr = 0;
    collect(12);
    checks++;
    if (npulse != 2 || gi[0] != 1 || gi[1] != 5 || gc[0] != 1 || gc[1] != 1) begin
      failures++;
      $display("FAIL back_to_back got n=%0d at=%0d,%0d required n=2 at=1,5", npulse, gi[0], gi[1]);
    end
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_ovf got=%b required=0", ovf);
    end
  endtask

  task automatic test_busy_hold();
    do_reset();
    busy = 1;
    nr = 1; dr = 1;
    step();
    nr = 0; dr = 0;
    collect(10);
    checks++;
    if (npulse != 0) begin
      failures++;
      $display("FAIL busy_block got pulses=%0d required=0", npulse);
    end
    busy = 0;
    collect(8);
    checks++;
    if (npulse != 2 || gi[0] != 1 || gi[1] != 5 || gc[0] != 1 || gc[1] != 2) begin
      failures++;
      $display("FAIL busy_release got n=%0d at=%0d,%0d required n=2 at=1,5", npulse, gi[0], gi[1]);
    end
  endtask

  task automatic test_soda_hold();
    do_reset();
    nr = 1; dr = 1;
    step();
    nr = 0; dr = 0;
    clear_rec();
    for (int i = 1; i <= 16; i++) begin
      step_rec(i);
      if (i == 3) begin soda = 1; busy = 1; end
      if (i == 4) soda = 0;
      if (i == 9) busy = 0;
    end
    checks++;
    if (npulse != 2 || gi[0] != 2 || gi[1] != 11 || gc[1] != 2) begin
      failures++;
      $display("FAIL soda_busy_hold got n=%0d at=%0d,%0d required n=2 at=2,11", npulse, gi[0], gi[1]);
    end
    do_reset();
    nr = 1; dr = 1;
    step();
    nr = 0; dr = 0;
    clear_rec();
    for (int i = 1; i <= 12; i++) begin
      step_rec(i);
      if (i == 3) soda = 1;
      if (i == 4) soda = 0;
    end
    checks++;
    if (npulse != 2 || gi[0] != 2 || gi[1] != 7) begin
      failures++;
      $display("FAIL soda_only_hold got n=%0d at=%0d,%0d required n=2 at=2,7", npulse, gi[0], gi[1]);
    end
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    busy = 1;
    for (int k = 0; k < 4; k++) begin
      nr = 1;
      step();
      nr = 0;
      step();
    end
    checks++;
    if (full !== 1'b1 || rej !== 1'b0) begin
      failures++;
      $display("FAIL ovf_full got full=%b rej=%b required full=1 rej=0", full, rej);
    end
    nr = 1;
    step();
    nr = 0;
    step();
    checks++;
    if (rej !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pending got rej=%b ovf=%b required 0 0", rej, ovf);
    end
    nr = 1;
    step();
    nr = 0;
    checks++;
    if (rej !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_reject got rej=%b ovf=%b required 1 1", rej, ovf);
    end
    step();
    checks++;
    if (rej !== 1'b0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got rej=%b ovf=%b required 0 1", rej, ovf);
    end
    busy = 0;
    collect(30);
    bad = 0;
    for (int k = 0; k < npulse; k++) if (gc[k] != 1) bad++;
    checks++;
    if (npulse != 5 || bad != 0) begin
      failures++;
      $display("FAIL ovf_drain got n=%0d non_nickel=%0d required n=5 non_nickel=0", npulse, bad);
    end
    checks++;
    if (full !== 1'b0 || ovf !== 1'b1 || cnt !== 8'd5) begin
      failures++;
      $display("FAIL ovf_end got full=%b ovf=%b cnt=%0d required 0 1 5", full, ovf, cnt);
    end
    checks++;
    if (w_cnt !== 2'd1) begin
      failures++;
      $display("FAIL cnt_wrap got=%0d required=1", w_cnt);
    end
  endtask

  task automatic test_reset_mid();
    nr = 1; dr = 1; qr = 1;
    step();
    nr = 0; dr = 0; qr = 0;
    step();
    step();
    step();
    #3 rst = 1;
    #1;
    checks++;
    if ({on, od, oq, full, rej, ovf, cnt, w_cnt} !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid got=%b required=0", {on, od, oq, full, rej, ovf, cnt, w_cnt});
    end
    step();
    rst = 0;
    collect(15);
    checks++;
    if (npulse != 0 || cnt !== 8'd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after got n=%0d cnt=%0d ovf=%b required 0 0 0", npulse, cnt, ovf);
    end
  endtask

  initial begin
    rst = 0; nr = 0; dr = 0; qr = 0; soda = 0; busy = 0;
    test_reset();
    test_single_dime();
    test_simultaneous();
    test_back_to_back();
    test_busy_hold();
    test_soda_hold();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_coin_scheduler.md
Name: vend_coin_scheduler

Overview:
Front-end controller for the vending FSM. It captures coin-sensor pulses from three independent sensors, which may arrive together. It serializes them through a small FIFO and issues at most one one-hot, single-cycle coin pulse per vend transaction step. It also holds off issue while the dispense unit is busy. It sits between the coin-acceptor sensors and the vending FSM's i_nickel/i_dime/i_quarter inputs, so the FSM never sees simultaneous coins.

Parameters:
DEPTH, 4, coin FIFO entries (power of two, >=2)
GAP, 2, settle cycles after each issued pulse (>=1), covers the vending FSM's registered output latency
CNT_W, 8, width of issued-coin counter

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  asynchronous active-high reset
i_nickel_req  in  1  nickel sensor, 1 cycle high per coin
i_dime_req  in  1  dime sensor, 1 cycle high per coin
i_quarter_req  in  1  quarter sensor, 1 cycle high per coin
i_soda  in  1  vending FSM soda output, sampled during SETTLE
i_vend_busy  in  1  dispense unit busy; blocks issue
o_nickel  out  1  registered 1-cycle pulse to vending FSM
o_dime  out  1  registered 1-cycle pulse to vending FSM
o_quarter  out  1  registered 1-cycle pulse to vending FSM
o_fifo_full  out  1  FIFO holds DEPTH entries
o_reject  out  1  1-cycle pulse: a coin was dropped
o_overflow  out  1  sticky, set with any reject, cleared only by reset
o_coin_cnt  out  CNT_W  coins issued, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, i_rst=1): all outputs 0, pending flags 0, FIFO empty, RR pointer=nickel, state IDLE, counters 0. Reset mid-transaction discards pending and queued coins; no pulse may be emitted on the edge reset deasserts.
- Capture: each sensor has a 1-bit pending flag, set on the edge where its req=1.
  - If req=1 while that flag is already set and not granted that cycle: coin dropped, o_reject pulses next cycle, o_overflow set.
  - Same-cycle grant and new req on the same sensor: flag stays set, no reject.
- Arbitration: round-robin over pending flags, order nickel->dime->quarter.
  - One grant per cycle, only when FIFO not full.
  - Grant clears the flag, pushes a 2-bit code (01 nickel, 10 dime, 11 quarter), and advances the pointer to the sensor after the granted one.
  - FIFO full: no grant; flags hold.
- FIFO: DEPTH entries. Push and pop in the same cycle are allowed, including when full (pop frees the slot). o_fifo_full is registered and reflects occupancy after the edge.
- Issue FSM, states IDLE, ISSUE, SETTLE, HOLD:
  - IDLE: if FIFO non-empty and i_vend_busy=0, pop and go to ISSUE. The matching o_* is high for exactly the ISSUE cycle.
  - ISSUE -> SETTLE. Load settle counter with GAP-1. o_coin_cnt increments once.
  - SETTLE: count down. Latch soda_seen if i_soda=1 on any SETTLE cycle. At count 0: go to HOLD if soda_seen or i_vend_busy=1, else IDLE.
  - HOLD: stay while i_vend_busy=1. Leave to IDLE on the first cycle i_vend_busy=0. Clear soda_seen on exit.
- Latency: a req at edge t sets the flag. With an empty FIFO, state IDLE and not busy: grant/push at t+1, pop at t+2, pulse visible t+2..t+3.
- Spacing: minimum pulse-to-pulse spacing is GAP+2 cycles.
- Output invariants: at most one of o_nickel/o_dime/o_quarter is high in any cycle. They are never high outside ISSUE.
- Issue order equals FIFO push order.

Test Plan:
- Single dime, idle, busy=0: dime_req at cycle 5 -> o_dime high only in cycle 7, o_coin_cnt=1, no reject.
- Simultaneous nickel+dime+quarter at cycle 3, pointer=nickel -> pulses in order nickel, dime, quarter, spaced GAP+2=4 cycles apart (cycles 5, 9, 13), o_coin_cnt=3.
- i_vend_busy held high for 10 cycles with 2 coins queued -> no pulse until 1 cycle after busy falls; i_soda=1 during SETTLE then busy=1 for 6 cycles -> HOLD keeps the next coin until busy=0.
- Overflow: DEPTH=4. Busy=1, then 4 nickels enqueued, then a 5th nickel sets pending, then a 6th nickel -> o_fifo_full=1, o_reject pulses once, o_overflow=1 sticky. After busy drops, exactly 5 nickel pulses.
- Reset mid-SETTLE with 3 coins queued -> all outputs 0 immediately. No pulses after reset release without new reqs; o_overflow=0, o_coin_cnt=0.
- Counter wrap (CNT_W=2): 5 coins issued -> o_coin_cnt=1.
